// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_sequencer
// Description : Calculator sequencing controller. Builds operands A and B
//               from debounced decimal key codes, latches the operator, runs
//               the shared ALU through a start/done handshake and captures
//               the result or error for the display path.
// Ports       : clk/rst_n    - clock, asynchronous active-low reset
//               key/key_valid - key code (0-9 digit, 10-13 op, 14 EQ,
//                               15 CLR) with single-cycle qualifier
//               alu_*         - ALU operands/opcode/start out, done/result/
//                               err in
//               disp_value    - value to display, disp_err - error flag
//               busy          - ALU operation outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   key,
  input  logic         key_valid,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  input  logic         alu_err,
  output logic [W-1:0] disp_value,
  output logic         disp_err,
  output logic         busy
);

  localparam int             DCW          = $clog2(MAX_DIGITS + 1);
  localparam logic [DCW-1:0] c_MAX_DIGITS = DCW'(MAX_DIGITS);
  localparam logic [3:0]     c_KEY_EQ     = 4'd14;
  localparam logic [3:0]     c_KEY_CLR    = 4'd15;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_EXEC    = 3'd2,
    S_WAIT    = 3'd3,
    S_RESULT  = 3'd4,
    S_ERROR   = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_opa, w_opa_nxt;
  logic [W-1:0]   r_opb, w_opb_nxt;
  logic [1:0]     r_op, w_op_nxt;
  logic [DCW-1:0] r_dcnt, w_dcnt_nxt;
  logic [W-1:0]   r_disp, w_disp_nxt;
  logic           r_err, w_err_nxt;
  logic [W-1:0]   r_alu_a, w_alu_a_nxt;
  logic [W-1:0]   r_alu_b, w_alu_b_nxt;
  logic [1:0]     r_alu_op, w_alu_op_nxt;
  logic           r_alu_start;
  logic           r_busy;
  logic           w_clear;

  // Key decode, qualified by the strobe
  logic           w_digit, w_oper, w_eq, w_clr, w_room;
  logic [1:0]     w_key_op;
  logic [W-1:0]   w_acc_a, w_acc_b, w_digit_val;

  function automatic logic [W-1:0] f_acc(input logic [W-1:0] v,
                                         input logic [W-1:0] d);
    f_acc = (v * W'(10)) + d;
  endfunction

  assign w_digit     = key_valid && (key < 4'd10);
  assign w_oper      = key_valid && (key >= 4'd10) && (key <= 4'd13);
  assign w_eq        = key_valid && (key == c_KEY_EQ);
  assign w_clr       = key_valid && (key == c_KEY_CLR);
  assign w_room      = (r_dcnt < c_MAX_DIGITS);
  // key-10 on the low two bits: 10->0, 11->1, 12->2, 13->3
  assign w_key_op    = key[1:0] + 2'd2;
  assign w_digit_val = {{(W-4){1'b0}}, key};
  assign w_acc_a     = f_acc(r_opa, w_digit_val);
  assign w_acc_b     = f_acc(r_opb, w_digit_val);

  always_comb begin
    w_state_nxt  = r_state;
    w_opa_nxt    = r_opa;
    w_opb_nxt    = r_opb;
    w_op_nxt     = r_op;
    w_dcnt_nxt   = r_dcnt;
    w_disp_nxt   = r_disp;
    w_err_nxt    = r_err;
    w_alu_a_nxt  = r_alu_a;
    w_alu_b_nxt  = r_alu_b;
    w_alu_op_nxt = r_alu_op;
    w_clear      = 1'b0;

    unique case (r_state)
      S_ENTER_A: begin
        if (w_clr) begin
          w_clear = 1'b1;
        end else if (w_digit && w_room) begin
          w_opa_nxt  = w_acc_a;
          w_dcnt_nxt = r_dcnt + DCW'(1);
          w_disp_nxt = w_acc_a;
        end else if (w_oper) begin
          w_op_nxt    = w_key_op;
          w_opb_nxt   = '0;
          w_dcnt_nxt  = '0;
          w_state_nxt = S_ENTER_B;
        end
      end
      S_ENTER_B: begin
        if (w_clr) begin
          w_clear = 1'b1;
        end else if (w_digit && w_room) begin
          w_opb_nxt  = w_acc_b;
          w_dcnt_nxt = r_dcnt + DCW'(1);
          w_disp_nxt = w_acc_b;
        end else if (w_oper && (r_dcnt == '0)) begin
          w_op_nxt = w_key_op;
        end else if (w_eq && (r_dcnt != '0)) begin
          // Operands are frozen here and held until the ALU completes
          w_alu_a_nxt  = r_opa;
          w_alu_b_nxt  = r_opb;
          w_alu_op_nxt = r_op;
          w_state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          // A CLR landing with completion still wins, after the result
          if (w_clr) begin
            w_clear = 1'b1;
          end else if (alu_err) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_ERROR;
          end else begin
            w_opa_nxt   = alu_result;
            w_disp_nxt  = alu_result;
            w_state_nxt = S_RESULT;
          end
        end else if (w_clr) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (alu_done) begin
          w_clear = 1'b1;
        end
      end
      S_RESULT: begin
        if (w_clr) begin
          w_clear = 1'b1;
        end else if (w_digit) begin
          w_opa_nxt   = w_digit_val;
          w_dcnt_nxt  = DCW'(1);
          w_disp_nxt  = w_digit_val;
          w_state_nxt = S_ENTER_A;
        end else if (w_oper) begin
          w_op_nxt    = w_key_op;
          w_opb_nxt   = '0;
          w_dcnt_nxt  = '0;
          w_state_nxt = S_ENTER_B;
        end
      end
      S_ERROR: begin
        if (w_clr) begin
          w_clear = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_ENTER_A;
      end
    endcase

    if (w_clear) begin
      w_opa_nxt    = '0;
      w_opb_nxt    = '0;
      w_op_nxt     = '0;
      w_dcnt_nxt   = '0;
      w_disp_nxt   = '0;
      w_err_nxt    = 1'b0;
      w_alu_a_nxt  = '0;
      w_alu_b_nxt  = '0;
      w_alu_op_nxt = '0;
      w_state_nxt  = S_ENTER_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ENTER_A;
      r_opa       <= '0;
      r_opb       <= '0;
      r_op        <= '0;
      r_dcnt      <= '0;
      r_disp      <= '0;
      r_err       <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_opa       <= w_opa_nxt;
      r_opb       <= w_opb_nxt;
      r_op        <= w_op_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_disp      <= w_disp_nxt;
      r_err       <= w_err_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_alu_op    <= w_alu_op_nxt;
      // EXEC is entered only from ENTER_B on EQ, so one pulse per EQ
      r_alu_start <= (w_state_nxt == S_EXEC);
      r_busy      <= (w_state_nxt == S_EXEC) || (w_state_nxt == S_WAIT) ||
                     (w_state_nxt == S_DRAIN);
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign alu_start  = r_alu_start;
  assign disp_value = r_disp;
  assign disp_err   = r_err;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_sequencer
// Description : Directed self-checking bench for calc_sequencer; the bench
//               plays the role of the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

  localparam int W = 16;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_DIV = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_CLR = 4'd15;

  logic         clk;
  logic         rst_n;
  logic [3:0]   key;
  logic         key_valid;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_op;
  logic         alu_start;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic         alu_err;
  logic [W-1:0] disp_value;
  logic         disp_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  calc_sequencer #(.W(W), .MAX_DIGITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_valid  (key_valid),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_err   (disp_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (alu_start) start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the key was sampled
  task automatic press(input logic [3:0] k);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key       = 4'd0;
  endtask

  // ALU completion strobe; busy must still be high while done is presented
  task automatic reply(input logic [W-1:0] res, input logic err,
                       input logic exp_busy);
    alu_done   = 1'b1;
    alu_result = res;
    alu_err    = err;
    check("busy_at_done", busy, exp_busy);
    @(negedge clk);
    alu_done   = 1'b0;
    alu_err    = 1'b0;
    alu_result = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},     alu_a, 0);
    check({tag, "_b"},     alu_b, 0);
    check({tag, "_op"},    alu_op, 0);
    check({tag, "_start"}, alu_start, 0);
    check({tag, "_disp"},  disp_value, 0);
    check({tag, "_err"},   disp_err, 0);
    check({tag, "_busy"},  busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; key = '0; key_valid = 1'b0;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 12 + 5 = 17
    press(4'd1);  check("t1_disp1", disp_value, 1);
    press(4'd2);  check("t1_disp12", disp_value, 12);
    press(K_ADD); check("t1_disp_after_op", disp_value, 12);
    press(4'd5);  check("t1_disp5", disp_value, 5);
    check("t1_busy_idle", busy, 0);
    press(K_EQ);
    check("t1_start", alu_start, 1);
    check("t1_busy_exec", busy, 1);
    check("t1_a", alu_a, 12);
    check("t1_b", alu_b, 5);
    check("t1_op", alu_op, 0);
    @(negedge clk);
    check("t1_start_pulse", alu_start, 0);
    check("t1_busy_wait", busy, 1);
    press(4'd7);  // ignored in WAIT
    check("t1_wait_key_ignored", disp_value, 5);
    check("t1_a_hold", alu_a, 12);
    reply(16'd17, 1'b0, 1'b1);
    check("t1_disp17", disp_value, 17);
    check("t1_busy_drop", busy, 0);
    check("t1_one_start", start_cnt, 1);

    // Chain on result: 17 * 3, then a digit starts fresh
    press(K_MUL); press(4'd3); press(K_EQ);
    check("t4_a", alu_a, 17);
    check("t4_b", alu_b, 3);
    check("t4_op", alu_op, 2);
    @(negedge clk);
    reply(16'd51, 1'b0, 1'b1);
    check("t4_disp51", disp_value, 51);
    press(4'd8);  check("t4_disp8", disp_value, 8);
    press(4'd9);  check("t4_disp89", disp_value, 89);
    press(K_CLR); check("t4_clr", disp_value, 0);

    // 9 / 0 -> error
    press(4'd9); press(K_DIV); press(4'd0); press(K_EQ);
    check("t2_op", alu_op, 3);
    @(negedge clk);
    reply(16'd0, 1'b1, 1'b1);
    check("t2_err", disp_err, 1);
    check("t2_busy", busy, 0);
    press(4'd3); press(K_EQ);
    check("t2_err_hold", disp_err, 1);
    check("t2_disp_hold", disp_value, 0);
    check("t2_no_start", start_cnt, 3);
    press(K_CLR);
    check("t2_clr_err", disp_err, 0);
    check("t2_clr_disp", disp_value, 0);
    press(4'd7);  check("t2_enter_a", disp_value, 7);
    press(K_CLR);

    // Fifth digit ignored, then 1234 - 4
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("t3_disp1234", disp_value, 1234);
    press(K_SUB); press(4'd4); press(K_EQ);
    check("t3_a", alu_a, 1234);
    check("t3_b", alu_b, 4);
    check("t3_op", alu_op, 1);
    @(negedge clk);
    reply(16'd1230, 1'b0, 1'b1);
    check("t3_disp1230", disp_value, 1230);

    // CLR during WAIT, completion 5 cycles later is discarded
    press(K_ADD); press(4'd6); press(K_EQ);
    @(negedge clk);
    press(K_CLR);
    check("t5_busy_drain", busy, 1);
    press(4'd5);
    check("t5_drain_key_ignored", disp_value, 6);
    @(negedge clk); @(negedge clk);
    check("t5_busy_still", busy, 1);
    reply(16'd1236, 1'b0, 1'b1);
    check("t5_disp_zero", disp_value, 0);
    check("t5_busy_drop", busy, 0);
    press(4'd3);  check("t5_enter_a", disp_value, 3);

    // EQ with no B digits ignored; operator replaced before B digits
    press(K_CLR);
    press(4'd2); press(K_ADD); press(K_EQ);
    check("t7_eq_ignored_busy", busy, 0);
    check("t7_eq_ignored_start", start_cnt, 5);
    press(K_MUL); press(4'd4); press(K_EQ);
    check("t7_op_replaced", alu_op, 2);
    check("t7_a", alu_a, 2);
    check("t7_b", alu_b, 4);
    @(negedge clk);
    reply(16'd8, 1'b0, 1'b1);
    check("t7_disp8", disp_value, 8);

    // CLR coincident with done: completion then clear
    press(K_ADD); press(4'd1); press(K_EQ);
    @(negedge clk);
    key = K_CLR; key_valid = 1'b1;
    reply(16'd9, 1'b0, 1'b1);
    key_valid = 1'b0; key = '0;
    check("t8_disp_zero", disp_value, 0);
    check("t8_busy", busy, 0);
    press(4'd5);  check("t8_enter_a", disp_value, 5);

    // Asynchronous reset during WAIT, late done ignored
    press(K_CLR);
    press(4'd3); press(K_ADD); press(4'd4); press(K_EQ);
    @(negedge clk);
    check("t6_busy_wait", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    reply(16'd99, 1'b0, 1'b0);
    check("t6_late_done_disp", disp_value, 0);
    check("t6_late_done_busy", busy, 0);
    press(4'd5);  check("t6_enter_a", disp_value, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Top-level sequencing controller for the calculator.
- Accepts debounced keypad key codes and builds operand A and operand B as binary values from decimal digits.
- Latches the operator and drives the shared ALU through a start/done handshake.
- Captures the result or error for the display path.
- Replaces ad-hoc combinational control with a registered FSM.

Parameters:
- W, 16, operand/result width in bits; must satisfy W >= ceil(log2(10^MAX_DIGITS)).
- MAX_DIGITS, 4, maximum decimal digits accepted per operand.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key  in  4  key code: 0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQ, 15 CLR.
- key_valid  in  1  single-cycle strobe qualifying key.
- alu_a  out  W  operand A to ALU.
- alu_b  out  W  operand B to ALU.
- alu_op  out  2  00 add, 01 sub, 10 mul, 11 div.
- alu_start  out  1  one-cycle start pulse.
- alu_done  in  1  one-cycle completion strobe from ALU.
- alu_result  in  W  ALU result, valid with alu_done.
- alu_err  in  1  overflow/divide-by-zero flag, valid with alu_done.
- disp_value  out  W  value to display.
- disp_err  out  1  error indicator.
- busy  out  1  high while an ALU operation is outstanding.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state ENTER_A; opA=0, opB=0, op=00, dcnt=0. All outputs 0 (alu_a, alu_b, alu_op, alu_start, disp_value, disp_err, busy).
- Reset mid-operation: discards any in-flight ALU operation, and a later alu_done is ignored.
- States: ENTER_A, ENTER_B, EXEC, WAIT, RESULT, ERROR, DRAIN.
- Keys are acted on only in the cycle key_valid=1. All outputs are registered, so the effect appears one cycle after the strobe.
- Digit d, when dcnt < MAX_DIGITS: operand <= operand*10 + d (mod 2^W), dcnt++, disp_value <= new operand.
- Digit d, when dcnt == MAX_DIGITS: the key is ignored and nothing changes.
- ENTER_A, digit: updates opA.
- ENTER_A, operator: op <= key-10, opB <= 0, dcnt <= 0, go to ENTER_B.
- ENTER_A, EQ: ignored.
- ENTER_B, digit: updates opB.
- ENTER_B, operator with dcnt==0: replaces op.
- ENTER_B, operator with dcnt>0: ignored.
- ENTER_B, EQ with dcnt==0: ignored.
- ENTER_B, EQ with dcnt>0: go to EXEC.
- EXEC: lasts one cycle. alu_start=1; alu_a=opA, alu_b=opB, alu_op=op. Go to WAIT.
- alu_a, alu_b and alu_op hold stable from EXEC until alu_done is sampled.
- WAIT, alu_done with alu_err=0: opA <= alu_result, disp_value <= alu_result, go to RESULT.
- WAIT, alu_done with alu_err=1: disp_err <= 1, go to ERROR.
- WAIT, any key other than CLR: ignored.
- WAIT, CLR: go to DRAIN.
- DRAIN: waits for alu_done, discards the result and error, clears all registers, goes to ENTER_A. Keys in DRAIN are ignored.
- RESULT, digit: starts a fresh calculation: opA <= d, dcnt <= 1, go to ENTER_A.
- RESULT, operator: chains on the result: op latched, opB <= 0, dcnt <= 0, go to ENTER_B.
- RESULT, EQ: ignored.
- ERROR: only CLR is accepted. It clears disp_err, opA, opB, op, dcnt and disp_value, then goes to ENTER_A.
- CLR in ENTER_A, ENTER_B or RESULT: clears as in ERROR and goes to ENTER_A.
- busy=1 in EXEC, WAIT and DRAIN; 0 elsewhere.
- alu_done outside WAIT and DRAIN: ignored.
- key_valid coincident with alu_done in WAIT: alu_done is processed and the key is dropped, except CLR, which is honoured after completion by going to ENTER_A with all registers cleared.
- alu_start is never asserted twice for one EQ.

Test Plan:
- Keys 1,2,ADD,5,EQ; ALU returns done with result 17, err=0 → alu_a=12, alu_b=5, alu_op=00, one alu_start pulse; disp_value sequence 1, 12, 5, 17; busy high from EXEC through the done cycle.
- Keys 9,DIV,0,EQ; ALU returns done with err=1 → disp_err=1 and the state stays in ERROR; the following 3 and EQ keys are ignored; CLR → disp_err=0, disp_value=0.
- Keys 1,2,3,4,5 → disp_value=1234 and the fifth digit is ignored; then SUB,4,EQ → alu_a=1234, alu_b=4, alu_op=01.
- After a result of 17: keys MUL,3,EQ → alu_a=17, alu_b=3, alu_op=10; a subsequent digit 8 → disp_value=8 and a new opA.
- CLR during WAIT, with alu_done arriving 5 cycles later → result is not displayed, disp_value=0, state ENTER_A, busy drops the cycle after alu_done.
- rst_n asserted low during WAIT → all outputs 0 asynchronously; a late alu_done after release has no effect.
